// File: rtl/s247_core_scheduler.sv
// Round-robin job dispatcher for the geofence compute cores: issues jobs to idle
// enabled cores, collects results or timeouts, and streams them back in turn.
module s247_core_scheduler #(
  parameter int NUM_CORES  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sched_en,
  input  logic [NUM_CORES-1:0]            core_mask,
  input  logic                            halt_clr,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [ID_WIDTH-1:0]             job_id,
  input  logic [DATA_WIDTH-1:0]           job_lat,
  input  logic [DATA_WIDTH-1:0]           job_lon,
  output logic [NUM_CORES-1:0]            core_start,
  output logic [NUM_CORES-1:0]            core_enable,
  output logic [DATA_WIDTH-1:0]           disp_lat,
  output logic [DATA_WIDTH-1:0]           disp_lon,
  input  logic [NUM_CORES-1:0]            core_done,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_result,
  input  logic [NUM_CORES-1:0]            core_halt,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ID_WIDTH-1:0]             res_id,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] res_core,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic                            res_err,
  output logic [NUM_CORES-1:0]            busy_o,
  output logic [1:0]                      sched_state,
  output logic [15:0]                     jobs_done
);

  localparam int CW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW1 = CW + 1;
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [CW:0]           NC     = CW1'(NUM_CORES);
  localparam logic [CW-1:0]         LAST   = CW'(NUM_CORES - 1);
  localparam logic [TW-1:0]         TLAST  = TW'(TIMEOUT - 1);
  localparam logic [NUM_CORES-1:0]  CORE0  = {{(NUM_CORES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_CORES-1:0]  busy_q, pending_q, err_q, eligible, core_start_q;
  logic [TW-1:0]         timer_q  [NUM_CORES];
  logic [DATA_WIDTH-1:0] result_q [NUM_CORES];
  logic [ID_WIDTH-1:0]   tag_q    [NUM_CORES];
  logic [CW-1:0]         rr_disp_q, rr_res_q, res_sel_q;
  logic                  res_lock_q;
  logic [DATA_WIDTH-1:0] disp_lat_q, disp_lon_q;
  logic [15:0]           jobs_done_q;
  logic                  halt_any, disp_fire, res_xfer;
  logic [CW:0]           disp_pick, res_pick;

  // First set bit of vec at or after base, wrapping; MSB of the result flags a hit.
  function automatic logic [CW:0] rr_pick(input logic [NUM_CORES-1:0] vec,
                                          input logic [CW-1:0] base);
    logic [CW:0] hit;
    logic [CW:0] pos;
    hit = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      pos = {1'b0, base} + CW1'(j);
      if (pos >= NC) pos = pos - NC;
      if (vec[pos[CW-1:0]]) hit = {1'b1, pos[CW-1:0]};
    end
    return hit;
  endfunction

  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] k);
    return (k == LAST) ? '0 : k + 1'b1;
  endfunction

  // Both streams use plain valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; ready never depends on valid, and res_valid
  // holds its payload stable until that transfer.
  assign halt_any  = |core_halt;
  assign eligible  = core_mask & ~busy_q & ~pending_q;
  assign job_ready = (state_q == ST_RUN) && (|eligible);
  assign disp_pick = rr_pick(eligible, rr_disp_q);
  assign res_pick  = rr_pick(pending_q, rr_res_q);
  // A job accepted in the same cycle a halt appears is dropped, not started.
  assign disp_fire = job_valid && job_ready && !halt_any;
  assign res_xfer  = res_lock_q && res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (halt_any) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE:  if (sched_en) state_d = ST_RUN;
        ST_RUN:   if (!sched_en) state_d = ST_DRAIN;
        ST_DRAIN: if (sched_en) state_d = ST_RUN;
                  else if (busy_q == '0) state_d = ST_IDLE;
        ST_HALT:  if (halt_clr) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= '0;
      pending_q    <= '0;
      err_q        <= '0;
      rr_disp_q    <= '0;
      rr_res_q     <= '0;
      res_sel_q    <= '0;
      res_lock_q   <= 1'b0;
      core_start_q <= '0;
      disp_lat_q   <= '0;
      disp_lon_q   <= '0;
      jobs_done_q  <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        timer_q[i]  <= '0;
        result_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      core_start_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (state_q != ST_HALT && busy_q[i]) begin
          if (core_done[i]) begin
            result_q[i]  <= core_result[i*DATA_WIDTH +: DATA_WIDTH];
            err_q[i]     <= 1'b0;
            busy_q[i]    <= 1'b0;
            pending_q[i] <= 1'b1;
          end else if (timer_q[i] == TLAST) begin
            result_q[i]  <= '0;
            err_q[i]     <= 1'b1;
            busy_q[i]    <= 1'b0;
            pending_q[i] <= 1'b1;
          end else begin
            timer_q[i] <= timer_q[i] + 1'b1;
          end
        end
      end
      if (disp_fire) begin
        busy_q[disp_pick[CW-1:0]]  <= 1'b1;
        timer_q[disp_pick[CW-1:0]] <= '0;
        tag_q[disp_pick[CW-1:0]]   <= job_id;
        core_start_q               <= CORE0 << disp_pick[CW-1:0];
        disp_lat_q                 <= job_lat;
        disp_lon_q                 <= job_lon;
        rr_disp_q                  <= rr_next(disp_pick[CW-1:0]);
      end
      if (halt_any) busy_q <= '0;
      if (res_xfer) begin
        pending_q[res_sel_q] <= 1'b0;
        rr_res_q             <= rr_next(res_sel_q);
        jobs_done_q          <= jobs_done_q + 16'd1;
        res_lock_q           <= 1'b0;
      end else if (!res_lock_q && res_pick[CW]) begin
        res_lock_q <= 1'b1;
        res_sel_q  <= res_pick[CW-1:0];
      end
    end
  end

  assign core_start  = core_start_q;
  assign core_enable = (state_q == ST_RUN || state_q == ST_DRAIN) ? core_mask : '0;
  assign disp_lat    = disp_lat_q;
  assign disp_lon    = disp_lon_q;
  assign res_valid   = res_lock_q;
  assign res_core    = res_lock_q ? res_sel_q : '0;
  assign res_id      = res_lock_q ? tag_q[res_sel_q] : '0;
  assign res_data    = res_lock_q ? result_q[res_sel_q] : '0;
  assign res_err     = res_lock_q && err_q[res_sel_q];
  assign busy_o      = busy_q;
  assign sched_state = state_q;
  assign jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_s247_core_scheduler.sv
// Bench for s247_core_scheduler: directed scenarios plus a randomized run
// compared every cycle against a job-level reference model.
module tb_s247_core_scheduler;

  localparam int NC = 8;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              sched_en, halt_clr, job_valid, job_ready, res_valid, res_ready, res_err;
  logic [NC-1:0]     core_mask, core_start, core_enable, core_done, core_halt, busy_o;
  logic [IW-1:0]     job_id, res_id;
  logic [DW-1:0]     job_lat, job_lon, disp_lat, disp_lon, res_data;
  logic [NC*DW-1:0]  core_result;
  logic [2:0]        res_core;
  logic [1:0]        sched_state;
  logic [15:0]       jobs_done;

  s247_core_scheduler #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .core_mask(core_mask),
    .halt_clr(halt_clr), .job_valid(job_valid), .job_ready(job_ready),
    .job_id(job_id), .job_lat(job_lat), .job_lon(job_lon),
    .core_start(core_start), .core_enable(core_enable),
    .disp_lat(disp_lat), .disp_lon(disp_lon), .core_done(core_done),
    .core_result(core_result), .core_halt(core_halt), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_core(res_core),
    .res_data(res_data), .res_err(res_err), .busy_o(busy_o),
    .sched_state(sched_state), .jobs_done(jobs_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference model: job table per core plus the two round-robin cursors
  int          m_state, m_rr_disp, m_rr_res, m_sel, m_jobs;
  logic [NC-1:0] m_busy, m_pend, m_err, m_start;
  int          m_timer  [NC];
  logic [31:0] m_result [NC];
  logic [7:0]  m_tag    [NC];
  logic        m_lock;
  logic [31:0] m_dlat, m_dlon;
  logic [43:0] exp_q[$];

  function automatic int first_from(input logic [NC-1:0] v, input int base);
    for (int j = 0; j < NC; j++) begin
      int p;
      p = (base + j) % NC;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic model_ready();
    return (m_state == 1) && ((core_mask & ~m_busy & ~m_pend) != 0);
  endfunction

  task automatic model_reset();
    m_state = 0; m_rr_disp = 0; m_rr_res = 0; m_sel = 0; m_jobs = 0;
    m_busy = '0; m_pend = '0; m_err = '0; m_start = '0; m_lock = 1'b0;
    m_dlat = '0; m_dlon = '0;
    for (int i = 0; i < NC; i++) begin
      m_timer[i] = 0; m_result[i] = '0; m_tag[i] = '0;
    end
  endtask

  task automatic model_step();
    logic [NC-1:0] busy0, pend0, elig;
    logic          halt_any, fire, xfer;
    int            ns, k;
    busy0 = m_busy; pend0 = m_pend;
    elig = core_mask & ~busy0 & ~pend0;
    halt_any = (core_halt != 0);
    fire = job_valid && model_ready() && !halt_any;
    xfer = m_lock && res_ready;
    ns = m_state;
    if (halt_any) ns = 3;
    else if (m_state == 0 && sched_en) ns = 1;
    else if (m_state == 1 && !sched_en) ns = 2;
    else if (m_state == 2) ns = sched_en ? 1 : ((busy0 == 0) ? 0 : 2);
    else if (m_state == 3 && halt_clr) ns = 0;
    if (m_state != 3) begin
      for (int i = 0; i < NC; i++) begin
        if (busy0[i] && core_done[i]) begin
          m_result[i] = core_result[i*DW +: DW]; m_err[i] = 1'b0;
          m_busy[i] = 1'b0; m_pend[i] = 1'b1;
        end else if (busy0[i] && m_timer[i] == TO - 1) begin
          m_result[i] = '0; m_err[i] = 1'b1; m_busy[i] = 1'b0; m_pend[i] = 1'b1;
        end else if (busy0[i]) begin
          m_timer[i]++;
        end
      end
    end
    m_start = '0;
    if (fire) begin
      k = first_from(elig, m_rr_disp);
      m_busy[k] = 1'b1; m_timer[k] = 0; m_tag[k] = job_id;
      m_start = 8'd1 << k; m_dlat = job_lat; m_dlon = job_lon;
      m_rr_disp = (k + 1) % NC;
    end
    if (halt_any) m_busy = '0;
    if (xfer) begin
      m_pend[m_sel] = 1'b0; m_rr_res = (m_sel + 1) % NC;
      m_jobs = (m_jobs + 1) % 65536; m_lock = 1'b0;
    end else if (!m_lock && pend0 != 0) begin
      m_sel = first_from(pend0, m_rr_res); m_lock = 1'b1;
    end
    m_state = ns;
  endtask

  // one clock: compare all outputs with the model, then advance both across the edge
  task automatic tick();
    logic [43:0] exp_res;
    #1;
    exp_res = m_lock ? {m_tag[m_sel], 3'(m_sel), m_result[m_sel], m_err[m_sel]} : 44'd0;
    check("job_ready",   job_ready,   model_ready());
    check("core_start",  core_start,  m_start);
    check("core_enable", core_enable, (m_state == 1 || m_state == 2) ? core_mask : 8'h00);
    check("disp_lat",    disp_lat,    m_dlat);
    check("disp_lon",    disp_lon,    m_dlon);
    check("busy",        busy_o,      m_busy);
    check("state",       sched_state, m_state);
    check("jobs_done",   jobs_done,   m_jobs);
    check("res_valid",   res_valid,   m_lock);
    check("res_payload", {res_id, res_core, res_data, res_err}, exp_res);
    if (m_lock && res_ready) exp_q.push_back(exp_res);
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) check("sb_spurious", 1, 0);
      else check("sb_result", {res_id, res_core, res_data, res_err}, exp_q.pop_front());
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sched_en = 1'b0; core_mask = '0; halt_clr = 1'b0;
    job_valid = 1'b0; job_id = '0; job_lat = '0; job_lon = '0;
    core_done = '0; core_result = '0; core_halt = '0; res_ready = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_job(input logic [7:0] id, input logic [31:0] lat, input logic [31:0] lon);
    job_valid = 1'b1; job_id = id; job_lat = lat; job_lon = lon;
    tick();
  endtask

  task automatic start_run();
    do_reset();
    sched_en = 1'b1; core_mask = 8'hFF;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int halt_left;
    do_reset();
    check("rst_state", sched_state, 0);
    check("rst_ready", job_ready, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rvalid", res_valid, 0);
    check("rst_jobs", jobs_done, 0);
    check("rst_start", core_start, 0);

    // three back-to-back jobs land on cores 0, 1, 2
    sched_en = 1'b1; core_mask = 8'hFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      send_job(8'(i + 1), 32'h0001_0000 * (i + 1), 32'h0A00_0000 + i);
      check("b2b_start", core_start, 8'h01 << i);
      check("b2b_lat", disp_lat, 32'h0001_0000 * (i + 1));
      check("b2b_ready", job_ready, 1);
    end

    // fill all cores, then free core 5 and refill it
    start_run();
    for (int i = 1; i <= 8; i++) send_job(8'(i), 32'(i), 32'(i));
    send_job(8'd9, 32'h99, 32'h99);
    check("full_ready", job_ready, 0);
    core_done = 8'h20; core_result[5*DW +: DW] = 32'h0001_0000;
    tick();
    core_done = '0;
    tick();
    check("d5_valid", res_valid, 1);
    check("d5_core", res_core, 5);
    check("d5_id", res_id, 6);
    check("d5_err", res_err, 0);
    check("d5_data", res_data, 32'h0001_0000);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("refill_ready", job_ready, 1);
    tick();
    check("refill_start", core_start, 8'h20);
    job_valid = 1'b0;

    // timeout on core 0
    start_run();
    send_job(8'h33, 32'h1, 32'h2);
    job_valid = 1'b0;
    for (int c = 1; c <= 15; c++) tick();
    check("to_busy_last", busy_o[0], 1);
    for (int w = 0; w < 6 && !res_valid; w++) tick();
    check("to_valid", res_valid, 1);
    check("to_err", res_err, 1);
    check("to_data", res_data, 0);
    check("to_id", res_id, 8'h33);
    check("to_busy", busy_o[0], 0);

    // simultaneous completions: core 2 first and held, then core 6
    start_run();
    for (int i = 0; i < 7; i++) send_job(8'(10 + i), 32'(i), 32'(i));
    job_valid = 1'b0;
    core_done = 8'h44;
    core_result[2*DW +: DW] = 32'hCAFE_0002; core_result[6*DW +: DW] = 32'hCAFE_0006;
    tick();
    core_done = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_core", res_core, 2);
      check("hold_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    tick();
    tick();
    check("second_core", res_core, 6);
    check("second_data", res_data, 32'hCAFE_0006);
    tick();
    res_ready = 1'b0;
    check("two_done", jobs_done, 2);

    // drain with core 3 busy
    do_reset();
    sched_en = 1'b1; core_mask = 8'h08;
    tick();
    send_job(8'h40, 32'h3, 32'h3);
    check("drain_start", core_start, 8'h08);
    job_valid = 1'b0; sched_en = 1'b0;
    tick();
    check("drain_state", sched_state, 2);
    check("drain_ready", job_ready, 0);
    core_done = 8'h08;
    tick();
    core_done = '0;
    for (int w = 0; w < 3 && sched_state != 0; w++) tick();
    check("drain_idle", sched_state, 0);

    // halt while cores 0-2 busy
    start_run();
    for (int i = 0; i < 3; i++) send_job(8'(i), 32'(i), 32'(i));
    job_valid = 1'b0;
    core_halt = 8'h10;
    tick();
    check("halt_state", sched_state, 3);
    check("halt_enable", core_enable, 0);
    check("halt_ready", job_ready, 0);
    halt_clr = 1'b1;
    tick();
    check("halt_sticky", sched_state, 3);
    halt_clr = 1'b0; core_halt = '0;
    tick();
    check("halt_wait_clr", sched_state, 3);
    halt_clr = 1'b1;
    tick();
    halt_clr = 1'b0;
    check("halt_clear", sched_state, 0);

    // randomized traffic
    start_run();
    halt_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        do_reset();
        sched_en = 1'b1; core_mask = 8'hFF;
      end
      if ($urandom_range(63) == 0) sched_en = ~sched_en;
      if ($urandom_range(99) == 0) core_mask = 8'($urandom);
      else if ($urandom_range(99) == 0) core_mask = 8'hFF;
      job_valid = ($urandom_range(9) < 7);
      job_id = 8'($urandom); job_lat = $urandom; job_lon = $urandom;
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(11) == 0) core_done[i] = 1'b1;
        core_result[i*DW +: DW] = $urandom;
      end
      if (halt_left > 0) halt_left--;
      if (halt_left == 0) core_halt = '0;
      if (core_halt == 0 && $urandom_range(299) == 0) begin
        core_halt = 8'($urandom_range(255, 1));
        halt_left = $urandom_range(4, 1);
      end
      halt_clr = ($urandom_range(7) == 0);
      res_ready = ($urandom_range(9) < 6);
      tick();
    end
    job_valid = 1'b0; core_halt = '0; res_ready = 1'b1;
    for (int c = 0; c < 60; c++) tick();
    check("sb_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s247_core_scheduler.md
Name: s247_core_scheduler

Overview:
Job dispatcher between the Wishbone register file and the NUM_CORES geofence compute cores. It accepts GPS-fix jobs over a valid/ready stream and issues each job to an idle, enabled core in round-robin order. It captures per-core results, enforces a per-core timeout, and returns results over a second valid/ready stream. Any core halt latches a global emergency stop.

Parameters:
NUM_CORES, 8, number of compute cores scheduled
DATA_WIDTH, 32, width of lat/lon/result words
ID_WIDTH, 8, job tag width
TIMEOUT, 1024, max busy cycles per job before forced completion (≥2)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
sched_en  in  1  run request (from control register)
core_mask  in  NUM_CORES  per-core allow mask
halt_clr  in  1  pulse; clears latched emergency stop
job_valid  in  1  job offered
job_ready  out  1  job accepted this cycle when job_valid is also high
job_id  in  ID_WIDTH  job tag
job_lat  in  DATA_WIDTH  GPS latitude, Q16.16
job_lon  in  DATA_WIDTH  GPS longitude, Q16.16
core_start  out  NUM_CORES  one-hot start pulse
core_enable  out  NUM_CORES  core enable levels
disp_lat  out  DATA_WIDTH  dispatched latitude, valid with core_start
disp_lon  out  DATA_WIDTH  dispatched longitude, valid with core_start
core_done  in  NUM_CORES  per-core one-cycle completion pulse
core_result  in  NUM_CORES*DATA_WIDTH  packed results, core i at [i*DW +: DW]
core_halt  in  NUM_CORES  per-core halt levels
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_id  out  ID_WIDTH  tag of returned job
res_core  out  clog2(NUM_CORES)  core index that produced the result
res_data  out  DATA_WIDTH  result word (0 on timeout)
res_err  out  1  1 = timeout completion
busy_o  out  NUM_CORES  per-core busy flags
sched_state  out  2  0 IDLE, 1 RUN, 2 DRAIN, 3 HALT
jobs_done  out  16  count of results delivered, wraps at 0xFFFF→0

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All busy, pending, err, timers, round-robin pointers, core_start, disp_lat/lon, res lock and jobs_done cleared to 0. Outputs therefore 0. Reset mid-job discards all in-flight and pending results.
- FSM: IDLE→RUN when sched_en=1. RUN→DRAIN when sched_en=0. DRAIN→RUN when sched_en=1. DRAIN→IDLE when busy==0. Any state→HALT when |core_halt. HALT→IDLE when halt_clr=1 and core_halt==0. Halt has priority over all other transitions.
- eligible[i] = core_mask[i] & ~busy[i] & ~pending[i]. job_ready = (state==RUN) & |eligible. job_ready is combinational from registers only, never from job_valid.
- Dispatch: when job_valid&job_ready at edge T, pick the first eligible index ≥ rr_disp, wrapping around. At T+1: core_start one-hot for exactly one cycle, disp_lat/disp_lon/tag registered, busy[k]=1, timer[k]=0, rr_disp=k+1 mod N. Maximum one dispatch per cycle.
- core_enable = core_mask in RUN/DRAIN, else 0. Forced 0 from the cycle after halt is seen.
- Completion: core_done[i]&busy[i] → latch result[i] and err[i]=0, busy[i]=0, pending[i]=1. core_done on a non-busy core is ignored.
- Timeout: timer[i] increments every busy cycle. When it reaches TIMEOUT-1 with no done → busy[i]=0, pending[i]=1, err[i]=1, result[i]=0. If done and timeout occur in the same cycle, done wins.
- Result port: when unlocked and |pending, select the first pending index ≥ rr_res and lock it. res_valid=1 while locked. Selection is held stable until res_valid&res_ready. On transfer: pending[sel]=0, rr_res=sel+1, jobs_done+1, unlock. Next result is presented earliest 1 cycle later.
- HALT: busy cleared, timers frozen, no dispatch. Pending results remain deliverable. core_done during HALT is ignored.
- Mask bit cleared while its core is busy: the job completes normally, and the core is ineligible afterwards.

Test Plan:
- Reset, sched_en=1, mask=0xFF, 3 back-to-back jobs (ids 1,2,3) → core_start 0x01,0x02,0x04 on consecutive cycles, job_ready stays 1, disp_lat matches each job.
- 8 jobs, no done, 9th offered → job_ready=0. done[5] with result 0x0001_0000 → res_valid, res_core=5, res_id=6, res_err=0. After accept, 9th job goes to core 5.
- TIMEOUT=16, job to core 0, no done → at cycle 16 after start: res_valid, res_err=1, res_data=0, busy_o[0]=0.
- done[2] and done[6] same cycle, res_ready=0 for 5 cycles → res_core=2 held stable. Then res_core=6 one cycle after accept. jobs_done=2.
- Core 3 busy, sched_en→0 → state DRAIN, job_ready=0. done[3] → IDLE next cycle.
- core_halt[4]=1 while cores 0–2 busy → next cycle sched_state=3, core_enable=0, job_ready=0. halt_clr with halt still high → stays HALT. halt low then halt_clr → IDLE.
